// File: rtl/spi_flash_responder.sv
// SPI flash target answering READ (03), status (05) and JEDEC-ID (9F) from a byte-wide memory port.
// Define FLASH_RESP_FASTREAD_EN to also serve FAST_READ (0B) with 8 dummy clocks.
`timescale 1ns/1ps
module spi_flash_responder #(
  parameter int unsigned ADDR_BITS   = 24,
  parameter logic [23:0] JEDEC_ID    = 24'hEF4018,
  parameter logic [7:0]  STATUS_VAL  = 8'h00,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 flash_csb,
  input  logic                 flash_clk,
  input  logic                 flash_io0_di,
  output logic                 flash_io1_do,
  output logic                 flash_io1_oe,
  output logic                 mem_valid,
  input  logic                 mem_ready,
  output logic [ADDR_BITS-1:0] mem_addr,
  input  logic [7:0]           mem_rdata,
  output logic                 busy,
  output logic                 underrun
);

`ifdef FLASH_RESP_FASTREAD_EN
  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_STATUS, S_ID, S_IGNORE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_STATUS, S_ID, S_IGNORE} state_t;
`endif

  logic [SYNC_STAGES-1:0] csb_sync, sck_sync, io0_sync;
  logic                   csb_s, sck_s, io0_s, csb_q, sck_q;
  logic                   sck_rise, sck_fall, csb_rise, csb_fall;
  state_t                 state, state_nxt;
  logic [22:0]            sh_in;
  logic [4:0]             bit_cnt;
  logic [7:0]             cmd_byte, sh_out, next_byte, pf_buf;
  logic [23:0]            addr_word;
  logic [2:0]             out_cnt;
  logic [1:0]             id_idx;
  logic                   do_bit, pf_full, drop;
  logic [ADDR_BITS-1:0]   slot_addr;
  logic                   xfer, mem_free, addr_done, boundary, out_state, fetch_st;
`ifdef FLASH_RESP_FASTREAD_EN
  logic                   fast;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      csb_sync <= '1;
      sck_sync <= '0;
      io0_sync <= '0;
      csb_q    <= 1'b1;
      sck_q    <= 1'b0;
    end else begin
      csb_sync <= {csb_sync[SYNC_STAGES-2:0], flash_csb};
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], flash_clk};
      io0_sync <= {io0_sync[SYNC_STAGES-2:0], flash_io0_di};
      csb_q    <= csb_s;
      sck_q    <= sck_s;
    end
  end

  assign csb_s     = csb_sync[SYNC_STAGES-1];
  assign sck_s     = sck_sync[SYNC_STAGES-1];
  assign io0_s     = io0_sync[SYNC_STAGES-1];
  assign sck_rise  = sck_s & ~sck_q;
  assign sck_fall  = ~sck_s & sck_q;
  assign csb_rise  = csb_s & ~csb_q;
  assign csb_fall  = ~csb_s & csb_q;
  assign busy      = ~csb_s;
  assign cmd_byte  = {sh_in[6:0], io0_s};
  assign addr_word = {sh_in, io0_s};
  assign addr_done = (state == S_ADDR) && sck_rise && (bit_cnt == 5'd23);
  assign out_state = (state == S_DATA) || (state == S_STATUS) || (state == S_ID);
  assign boundary  = (state == S_DATA) && (state_nxt == S_DATA) && sck_fall && (out_cnt == 3'd0);
  assign xfer      = mem_valid & mem_ready;
  assign mem_free  = ~mem_valid | xfer;
`ifdef FLASH_RESP_FASTREAD_EN
  assign fetch_st  = (state == S_DATA) || (state == S_DUMMY);
`else
  assign fetch_st  = (state == S_DATA);
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (csb_rise) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (csb_fall) state_nxt = S_CMD;
        S_CMD: if (sck_rise && bit_cnt == 5'd7) begin
          case (cmd_byte)
            8'h03:   state_nxt = S_ADDR;
            8'h05:   state_nxt = S_STATUS;
            8'h9F:   state_nxt = S_ID;
`ifdef FLASH_RESP_FASTREAD_EN
            8'h0B:   state_nxt = S_ADDR;
`endif
            default: state_nxt = S_IGNORE;
          endcase
        end
`ifdef FLASH_RESP_FASTREAD_EN
        S_ADDR:  if (addr_done) state_nxt = fast ? S_DUMMY : S_DATA;
        S_DUMMY: if (sck_rise && bit_cnt == 5'd7) state_nxt = S_DATA;
`else
        S_ADDR:  if (addr_done) state_nxt = S_DATA;
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    flash_io1_oe = out_state & ~csb_s;
    flash_io1_do = flash_io1_oe ? do_bit : 1'b1;
  end

  always_comb begin
    next_byte = 8'hFF;
    case (state)
      S_STATUS: next_byte = STATUS_VAL;
      S_DATA:   next_byte = pf_full ? pf_buf : 8'hFF;
      S_ID: case (id_idx)
        2'd0:    next_byte = JEDEC_ID[23:16];
        2'd1:    next_byte = JEDEC_ID[15:8];
        2'd2:    next_byte = JEDEC_ID[7:0];
        default: next_byte = 8'hFF;
      endcase
      default: ;
    endcase
  end

  // Bit counters restart on every state change; output bytes load on the fall with out_cnt==0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sh_in   <= '0;
      bit_cnt <= '0;
      sh_out  <= '1;
      out_cnt <= '0;
      id_idx  <= '0;
      do_bit  <= 1'b1;
`ifdef FLASH_RESP_FASTREAD_EN
      fast    <= 1'b0;
`endif
    end else begin
      if (sck_rise) sh_in <= {sh_in[21:0], io0_s};
`ifdef FLASH_RESP_FASTREAD_EN
      if (state == S_CMD && sck_rise && bit_cnt == 5'd7) fast <= (cmd_byte == 8'h0B);
`endif
      if (state_nxt != state || state == S_IDLE) begin
        bit_cnt <= '0;
        out_cnt <= '0;
        id_idx  <= '0;
        do_bit  <= 1'b1;
      end else begin
        if (sck_rise) bit_cnt <= bit_cnt + 5'd1;
        if (sck_fall && out_state) begin
          if (out_cnt == 3'd0) begin
            do_bit  <= next_byte[7];
            sh_out  <= {next_byte[6:0], 1'b1};
            out_cnt <= 3'd7;
            if (state == S_ID && id_idx != 2'd3) id_idx <= id_idx + 2'd1;
          end else begin
            do_bit  <= sh_out[7];
            sh_out  <= {sh_out[6:0], 1'b1};
            out_cnt <= out_cnt - 3'd1;
          end
        end
      end
    end
  end

  // slot_addr is the byte due at the next boundary; a request still pending when its slot is
  // consumed (underrun) or when csb rises is marked drop so its late data is discarded.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      slot_addr <= '0;
      pf_buf    <= '0;
      pf_full   <= 1'b0;
      drop      <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      if (xfer) begin
        mem_valid <= 1'b0;
        drop      <= 1'b0;
        if (!drop && fetch_st && !boundary) begin
          pf_buf  <= mem_rdata;
          pf_full <= 1'b1;
        end
      end
      if (csb_rise && mem_valid && !xfer) drop <= 1'b1;
      if (state == S_IDLE) pf_full <= 1'b0;
      if (addr_done) begin
        slot_addr <= addr_word[ADDR_BITS-1:0];
        pf_full   <= 1'b0;
        if (mem_free) begin
          mem_valid <= 1'b1;
          mem_addr  <= addr_word[ADDR_BITS-1:0];
        end
      end else if (boundary) begin
        slot_addr <= slot_addr + 1'b1;
        if (pf_full) begin
          pf_full <= 1'b0;
        end else begin
          underrun <= 1'b1;
          if (!mem_free) drop <= 1'b1;
        end
        if (mem_free) begin
          mem_valid <= 1'b1;
          mem_addr  <= slot_addr + 1'b1;
        end
      end else if (fetch_st && !mem_valid && !pf_full) begin
        mem_valid <= 1'b1;
        mem_addr  <= slot_addr;
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: a 24-bit and an 8-bit address instance share one SPI bus.
`timescale 1ns/1ps
module tb_spi_flash_responder;
  localparam int unsigned H = 8;  // flash_clk half period in clk cycles

  logic clk = 1'b0, resetn = 1'b0;
  logic flash_csb = 1'b1, flash_clk = 1'b0, flash_io0_di = 1'b0;
  logic io1_do, io1_oe, mv, busy, underrun;
  logic mr = 1'b0;
  logic [23:0] ma;
  logic [7:0]  rd = 8'h00;
  logic io1_do8, io1_oe8, mv8, busy8, underrun8;
  logic mr8 = 1'b0;
  logic [7:0]  ma8;
  logic [7:0]  rd8 = 8'h00;

  int unsigned n_checks = 0, n_pass = 0;
  logic [23:0] log_q[$];
  logic [7:0]  log8_q[$];
  logic        stall_en = 1'b0;
  int unsigned stall_cnt = 0, mv_cycles = 0, mv_snap;
  logic [7:0]  rx, rx8;
  logic        oe_or, oe_and, hdr_oe;

  always #5 clk = ~clk;

  spi_flash_responder #(.ADDR_BITS(24)) dut (
    .clk(clk), .resetn(resetn), .flash_csb(flash_csb), .flash_clk(flash_clk),
    .flash_io0_di(flash_io0_di), .flash_io1_do(io1_do), .flash_io1_oe(io1_oe),
    .mem_valid(mv), .mem_ready(mr), .mem_addr(ma), .mem_rdata(rd),
    .busy(busy), .underrun(underrun));

  spi_flash_responder #(.ADDR_BITS(8)) dut8 (
    .clk(clk), .resetn(resetn), .flash_csb(flash_csb), .flash_clk(flash_clk),
    .flash_io0_di(flash_io0_di), .flash_io1_do(io1_do8), .flash_io1_oe(io1_oe8),
    .mem_valid(mv8), .mem_ready(mr8), .mem_addr(ma8), .mem_rdata(rd8),
    .busy(busy8), .underrun(underrun8));

  // Memories hold mem[i] = i; one-cycle latency, optionally stalling one request by 64 cycles.
  always @(posedge clk) begin
    mr  <= 1'b0;
    mr8 <= 1'b0;
    if (mv) mv_cycles <= mv_cycles + 1;
    if (mv && !mr) begin
      if (stall_en && stall_cnt < 64) stall_cnt <= stall_cnt + 1;
      else begin
        mr <= 1'b1;
        rd <= ma[7:0];
        log_q.push_back(ma);
      end
    end
    if (mv8 && !mr8) begin
      mr8 <= 1'b1;
      rd8 <= ma8;
      log8_q.push_back(ma8);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int unsigned nbits);
    oe_or  = 1'b0;
    oe_and = 1'b1;
    rx     = 8'h00;
    rx8    = 8'h00;
    for (int unsigned i = 0; i < nbits; i++) begin
      flash_io0_di = tx[7 - i];
      repeat (H) @(negedge clk);
      rx     = {rx[6:0], io1_do};
      rx8    = {rx8[6:0], io1_do8};
      oe_or  = oe_or | io1_oe;
      oe_and = oe_and & io1_oe;
      flash_clk = 1'b1;
      repeat (H) @(negedge clk);
      flash_clk = 1'b0;
    end
  endtask

  task automatic cs_low();
    flash_csb = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (H) @(negedge clk);
    flash_csb = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic send_hdr(input logic [7:0] c, input logic [23:0] a);
    logic o;
    spi_bits(c, 8);        o = oe_or;
    spi_bits(a[23:16], 8); o = o | oe_or;
    spi_bits(a[15:8], 8);  o = o | oe_or;
    spi_bits(a[7:0], 8);   hdr_oe = o | oe_or;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (4) @(negedge clk);
    check_eq("rst_io1_oe", io1_oe, 0);
    check_eq("rst_io1_do", io1_do, 1);
    check_eq("rst_mem_valid", mv, 0);
    check_eq("rst_mem_addr", ma, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_underrun", underrun, 0);
    resetn = 1'b1;
    repeat (4) @(negedge clk);

    // 1: plain READ from 0x10
    log_q.delete();
    cs_low();
    check_eq("t1_busy", busy, 1);
    send_hdr(8'h03, 24'h000010);
    check_eq("t1_hdr_oe", hdr_oe, 0);
    for (int unsigned b = 0; b < 4; b++) begin
      spi_bits(8'h00, 8);
      check_eq($sformatf("t1_byte%0d", b), rx, 8'h10 + b);
      check_eq($sformatf("t1_oe%0d", b), oe_and, 1);
    end
    cs_high();
    check_eq("t1_nreq_ge5", (log_q.size() >= 5) ? 1 : 0, 1);
    for (int unsigned i = 0; i < 5; i++)
      check_eq($sformatf("t1_addr%0d", i), (i < log_q.size()) ? log_q[i] : 24'hxxxxxx, 24'h10 + i);
    check_eq("t1_underrun", underrun, 0);
    check_eq("t1_busy_off", busy, 0);
    check_eq("t1_oe_off", io1_oe, 0);

    // 2: 8-bit address instance wraps FF -> 00
    log8_q.delete();
    cs_low();
    send_hdr(8'h03, 24'h0000FE);
    spi_bits(8'h00, 8); check_eq("t2_byte0", rx8, 8'hFE);
    spi_bits(8'h00, 8); check_eq("t2_byte1", rx8, 8'hFF);
    spi_bits(8'h00, 8); check_eq("t2_byte2", rx8, 8'h00);
    cs_high();
    check_eq("t2_nreq_ge3", (log8_q.size() >= 3) ? 1 : 0, 1);
    for (int unsigned i = 0; i < 3; i++)
      check_eq($sformatf("t2_addr%0d", i), (i < log8_q.size()) ? log8_q[i] : 8'hxx, (8'hFE + i) & 8'hFF);

    // 3: JEDEC ID then status
    cs_low();
    spi_bits(8'h9F, 8);
    spi_bits(8'h00, 8); check_eq("t3_id0", rx, 8'hEF);
    spi_bits(8'h00, 8); check_eq("t3_id1", rx, 8'h40);
    spi_bits(8'h00, 8); check_eq("t3_id2", rx, 8'h18);
    spi_bits(8'h00, 8); check_eq("t3_id3", rx, 8'hFF);
    cs_high();
    cs_low();
    spi_bits(8'h05, 8);
    spi_bits(8'h00, 8); check_eq("t3_st0", rx, 8'h00);
    spi_bits(8'h00, 8); check_eq("t3_st1", rx, 8'h00);
    cs_high();

    // 4: unknown command keeps MISO off; following read is clean
    cs_low();
    spi_bits(8'h5A, 8);
    spi_bits(8'h00, 8); check_eq("t4_oe0", oe_or, 0);
    spi_bits(8'h00, 8); check_eq("t4_oe1", oe_or, 0);
    cs_high();
    cs_low();
    send_hdr(8'h03, 24'h000040);
    spi_bits(8'h00, 8); check_eq("t4_after", rx, 8'h40);
    cs_high();

    // 5: abort after 12 address bits
    mv_snap = mv_cycles;
    log_q.delete();
    cs_low();
    spi_bits(8'h03, 8);
    spi_bits(8'h00, 8);
    spi_bits(8'h00, 4);
    cs_high();
    check_eq("t5_abort_mv", mv_cycles - mv_snap, 0);
    cs_low();
    spi_bits(8'h03, 8);
    spi_bits(8'h00, 8);
    spi_bits(8'h00, 8);
    check_eq("t5_early_mv", mv_cycles - mv_snap, 0);
    spi_bits(8'h20, 8);
    spi_bits(8'h00, 8); check_eq("t5_byte0", rx, 8'h20);
    spi_bits(8'h00, 8); check_eq("t5_byte1", rx, 8'h21);
    cs_high();
    check_eq("t5_first_addr", (log_q.size() > 0) ? log_q[0] : 24'hxxxxxx, 24'h20);
    check_eq("t5_underrun", underrun, 0);

    // 6: stalled first fetch underruns; sticky flag survives a clean read
    stall_en = 1'b1;
    cs_low();
    send_hdr(8'h03, 24'h000030);
    spi_bits(8'h00, 8); check_eq("t6_byte0", rx, 8'hFF);
    spi_bits(8'h00, 8); check_eq("t6_byte1", rx, 8'h31);
    cs_high();
    check_eq("t6_underrun", underrun, 1);
    stall_en = 1'b0;
    cs_low();
    send_hdr(8'h03, 24'h000050);
    spi_bits(8'h00, 8); check_eq("t6_after", rx, 8'h50);
    cs_high();
    check_eq("t6_sticky", underrun, 1);
    check_eq("t6_dut8_underrun", underrun8, 0);

    // 0B: FAST_READ when built in, otherwise ignored
    mv_snap = mv_cycles;
    cs_low();
`ifdef FLASH_RESP_FASTREAD_EN
    send_hdr(8'h0B, 24'h000004);
    spi_bits(8'h00, 8); check_eq("t7_dummy_oe", oe_or, 0);
    spi_bits(8'h00, 8); check_eq("t7_byte0", rx, 8'h04);
    spi_bits(8'h00, 8); check_eq("t7_byte1", rx, 8'h05);
`else
    spi_bits(8'h0B, 8);
    spi_bits(8'h00, 8); check_eq("t7_ign_oe0", oe_or, 0);
    spi_bits(8'h00, 8); check_eq("t7_ign_oe1", oe_or, 0);
    spi_bits(8'h00, 8);
    spi_bits(8'h04, 8);
    spi_bits(8'h00, 8); check_eq("t7_ign_oe2", oe_or, 0);
    check_eq("t7_ign_mv", mv_cycles - mv_snap, 0);
`endif
    cs_high();
    check_eq("end_busy8", busy8, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
